rand_range_gen: RTL and testbench

Bounded random-number consumer that sits downstream of the 32-bit lfsr113 PRNG. On request it returns a uniformly distributed value in the inclusive range [lo, hi]. It uses masked rejection sampling over successive PRNG words, with a bounded retry count. Game logic (obstacle placement, spawn timing) uses it to get screen-coordinate-sized random values without biased modulo arithmetic.

---
 rtl/rand_range_gen.sv | 127 ++++++++++++
 tb/tb_rand_range_gen.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/rand_range_gen.sv
// Uniform random value in [lo, hi] via masked rejection over lfsr113 words; 3..2+MAX_TRIES cycles req->valid.
// No backpressure: req is sampled only in IDLE, ignored (not queued) while busy.
module rand_range_gen #(
  parameter int WIDTH     = 12,
  parameter int MAX_TRIES = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      prng_in,
  output logic             prng_enable,
  input  logic             req,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] value,
  output logic             valid,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAW, DONE} state_t;

  localparam logic [7:0]       LAST_TRY = 8'(MAX_TRIES - 1);
  localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] span_q, span_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [7:0]       tries_q, tries_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             en_q, en_d;

  logic [WIDTH-1:0] span_calc;
  logic [WIDTH-1:0] mask_calc;
  logic [WIDTH-1:0] cand;

  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    span_d  = span_q;
    mask_d  = mask_q;
    tries_d = tries_q;
    value_d = value_q;
    en_d    = en_q;

    span_calc = (hi_q < lo_q) ? '0 : (hi_q - lo_q);
    // Smear the top set bit downward to get the smallest all-ones mask covering span.
    mask_calc = span_calc;
    for (int i = 1; i < WIDTH; i++) begin
      mask_calc = mask_calc | (mask_calc >> i);
    end
    cand = prng_in[31:32-WIDTH] & mask_q;

    case (state_q)
      IDLE: begin
        if (req) begin
          lo_d    = lo;
          hi_d    = hi;
          tries_d = '0;
          en_d    = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        span_d  = span_calc;
        mask_d  = mask_calc;
        state_d = DRAW;
      end
      DRAW: begin
        if (cand <= span_q) begin
          value_d = lo_q + cand;
          state_d = DONE;
        end else if (tries_q == LAST_TRY) begin
          // Out-of-range candidates lie in (span, 2*span+1], so folding lands inside the range.
          value_d = lo_q + (cand - span_q - ONE_W);
          state_d = DONE;
        end else begin
          tries_d = tries_q + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    valid_d = (state_d == DONE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      lo_q    <= '0;
      hi_q    <= '0;
      span_q  <= '0;
      mask_q  <= '0;
      tries_q <= '0;
      value_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      span_q  <= span_d;
      mask_q  <= mask_d;
      tries_q <= tries_d;
      value_q <= value_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      en_q    <= en_d;
    end
  end

  assign value       = value_q;
  assign valid       = valid_q;
  assign busy        = busy_q;
  assign prng_enable = en_q;

endmodule

// File: tb/tb_rand_range_gen.sv
// Directed bench for rand_range_gen (WIDTH=12, MAX_TRIES=8) with hand-computed expectations.
module tb_rand_range_gen;

  logic        clk;
  logic        reset;
  logic [31:0] prng_in;
  logic        prng_enable;
  logic        req;
  logic [11:0] lo;
  logic [11:0] hi;
  logic [11:0] value;
  logic        valid;
  logic        busy;

  int total;
  int passed;
  int vcount;

  rand_range_gen #(.WIDTH(12), .MAX_TRIES(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .prng_in     (prng_in),
    .prng_enable (prng_enable),
    .req         (req),
    .lo          (lo),
    .hi          (hi),
    .value       (value),
    .valid       (valid),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Steps n cycles, counting valid pulses seen.
  task automatic count_valids(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (valid === 1'b1) cnt++;
    end
  endtask

  initial begin
    total   = 0;
    passed  = 0;
    reset   = 1'b1;
    req     = 1'b0;
    lo      = '0;
    hi      = '0;
    prng_in = '0;
    repeat (3) step();
    chk("rst_value", value, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_en", prng_enable, 0);
    reset = 1'b0;
    count_valids(4, vcount);
    chk("rst_no_valid", vcount, 0);

    // Single draw: cand = 0x00A & 0xFF = 10 -> 110
    lo = 12'd100; hi = 12'd355; prng_in = 32'h00A0_0000; req = 1'b1;
    step();  // cycle 1
    req = 1'b0;
    chk("single_c1_busy", busy, 1);
    chk("single_c1_en", prng_enable, 1);
    chk("single_c1_valid", valid, 0);
    step();  // cycle 2
    chk("single_c2_busy", busy, 1);
    chk("single_c2_valid", valid, 0);
    step();  // cycle 3
    chk("single_c3_valid", valid, 1);
    chk("single_c3_value", value, 110);
    chk("single_c3_busy", busy, 1);
    step();  // cycle 4
    chk("single_c4_valid", valid, 0);
    chk("single_c4_busy", busy, 0);
    chk("single_c4_en", prng_enable, 1);
    chk("single_c4_hold", value, 110);

    // Rejection: 7,7 rejected, then 3 accepted
    lo = 12'd0; hi = 12'd4; prng_in = 32'h0070_0000; req = 1'b1;
    step();  // cycle 1
    req = 1'b0;
    chk("rej_value_not_cleared", value, 110);
    step();  // cycle 2
    step();  // cycle 3
    chk("rej_c3_valid", valid, 0);
    step();  // cycle 4
    chk("rej_c4_valid", valid, 0);
    prng_in = 32'h0030_0000;
    step();  // cycle 5
    chk("rej_c5_valid", valid, 1);
    chk("rej_c5_value", value, 3);
    step();  // IDLE

    // Fold: 6 always rejected, 8th try folds to 6-4-1 = 1
    lo = 12'd0; hi = 12'd4; prng_in = 32'h0060_0000; req = 1'b1;
    step();  // cycle 1
    req = 1'b0;
    count_valids(8, vcount);  // cycles 2..9
    chk("fold_no_early_valid", vcount, 0);
    step();  // cycle 10
    chk("fold_c10_valid", valid, 1);
    chk("fold_c10_value", value, 1);
    step();
    chk("fold_idle_busy", busy, 0);

    // lo == hi
    lo = 12'd42; hi = 12'd42; prng_in = 32'hFFFF_FFFF; req = 1'b1;
    step();
    req = 1'b0;
    step();
    step();  // cycle 3
    chk("eq_valid", valid, 1);
    chk("eq_value", value, 42);
    step();

    // hi < lo collapses to lo
    lo = 12'd50; hi = 12'd20; prng_in = 32'h1234_5678; req = 1'b1;
    step();
    req = 1'b0;
    step();
    step();  // cycle 3
    chk("inv_valid", valid, 1);
    chk("inv_value", value, 50);
    step();

    // req pulse during DRAW is ignored
    lo = 12'd0; hi = 12'd4; prng_in = 32'h0070_0000; req = 1'b1;
    step();  // cycle 1
    req = 1'b0;
    step();  // cycle 2 (DRAW)
    req = 1'b1; lo = 12'd9; hi = 12'd9;
    step();  // cycle 3
    req = 1'b0;
    prng_in = 32'h0020_0000;
    step();  // cycle 4
    chk("ign_valid", valid, 1);
    chk("ign_value", value, 2);
    count_valids(12, vcount);
    chk("ign_single_valid", vcount, 0);

    // Reset during DRAW
    lo = 12'd0; hi = 12'd4; prng_in = 32'h0070_0000; req = 1'b1;
    step();  // cycle 1
    req = 1'b0;
    step();  // cycle 2 (DRAW)
    #3 reset = 1'b1;
    #1;
    chk("mid_rst_value", value, 0);
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_en", prng_enable, 0);
    #1 reset = 1'b0;
    prng_in = 32'h0010_0000;
    count_valids(12, vcount);
    chk("mid_rst_no_valid", vcount, 0);
    chk("mid_rst_en_low", prng_enable, 0);
    lo = 12'd7; hi = 12'd7; req = 1'b1;
    step();
    req = 1'b0;
    chk("post_rst_en", prng_enable, 1);
    step();
    chk("post_rst_c2_valid", valid, 0);
    step();  // cycle 3
    chk("post_rst_valid", valid, 1);
    chk("post_rst_value", value, 7);
    step();

    // Held req re-accepted in the IDLE cycle after DONE
    lo = 12'd5; hi = 12'd5; req = 1'b1;
    step();  // cycle 1
    step();  // cycle 2
    step();  // cycle 3
    chk("held_c3_valid", valid, 1);
    step();  // cycle 4 (IDLE, accepts)
    chk("held_c4_busy", busy, 0);
    step();  // cycle 5
    chk("held_c5_busy", busy, 1);
    req = 1'b0;
    step();
    step();  // cycle 7
    chk("held_second_valid", valid, 1);
    chk("held_second_value", value, 5);
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
